// File: rtl/mf8_ram_arb_pkg.sv
// mf8_ram_arb_pkg
//   Shared definitions for the mf8 data-RAM arbiter: host FSM state
//   encoding, data width and the default parameter values.
package mf8_ram_arb_pkg;

    localparam int DATA_W         = 8;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_STARVE_MAX = 15;

    typedef enum logic {
        H_IDLE = 1'b0,
        H_PEND = 1'b1
    } hstate_t;

endpackage

// File: rtl/mf8_ram_arb_if.sv
// mf8_ram_arb_if
//   Bundles the three buses around the arbiter.
//   Core side : Core_Addr/Core_Rd/Core_Wr/Core_WData in, Core_RData/Core_Ready out.
//   Host side : H_Valid/H_Wr/H_Addr/H_WData in, H_Ready/H_RValid/H_RData out.
//   RAM side  : M_En/M_We/M_Addr/M_WData out, M_RData in.
//   Status    : Starve out.
//   slave  = the arbiter's view, master = core + host + RAM environment.
interface mf8_ram_arb_if
    import mf8_ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();
    logic [15:0]       Core_Addr;
    logic              Core_Rd;
    logic              Core_Wr;
    logic [DATA_W-1:0] Core_WData;
    logic [DATA_W-1:0] Core_RData;
    logic              Core_Ready;

    logic              H_Valid;
    logic              H_Ready;
    logic              H_Wr;
    logic [ADDR_W-1:0] H_Addr;
    logic [DATA_W-1:0] H_WData;
    logic              H_RValid;
    logic [DATA_W-1:0] H_RData;

    logic              M_En;
    logic              M_We;
    logic [ADDR_W-1:0] M_Addr;
    logic [DATA_W-1:0] M_WData;
    logic [DATA_W-1:0] M_RData;

    logic              Starve;

    modport slave (
        input  Core_Addr, Core_Rd, Core_Wr, Core_WData,
        output Core_RData, Core_Ready,
        input  H_Valid, H_Wr, H_Addr, H_WData,
        output H_Ready, H_RValid, H_RData,
        output M_En, M_We, M_Addr, M_WData,
        input  M_RData,
        output Starve
    );

    modport master (
        output Core_Addr, Core_Rd, Core_Wr, Core_WData,
        input  Core_RData, Core_Ready,
        output H_Valid, H_Wr, H_Addr, H_WData,
        input  H_Ready, H_RValid, H_RData,
        input  M_En, M_We, M_Addr, M_WData,
        output M_RData,
        input  Starve
    );

endinterface

// File: rtl/mf8_ram_arb.sv
// mf8_ram_arb
//   Single-port data-RAM arbiter between the mf8 core and a host/DMA port.
//   The core never stalls: its strobes go straight to the RAM pins and its
//   read data is the raw RAM output. Host requests sit in a one-entry
//   holding register and are issued in the first cycle the core leaves
//   the RAM alone. A saturating counter flags host starvation.
//   Ports: Clk, Reset (synchronous, active-high), bus (mf8_ram_arb_if.slave).
module mf8_ram_arb
    import mf8_ram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic         Clk,
    input  logic         Reset,
    mf8_ram_arb_if.slave bus
);
    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    hstate_t           r_state;
    hstate_t           w_state_nxt;
    logic              r_req_wr;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_req_wdata;
    logic              r_rd_vld_p1;
    logic              r_rd_vld_p2;
    logic [DATA_W-1:0] r_rdata_p2;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_core_ready;
    logic              w_core_acc;
    logic              w_accept;
    logic              w_issue;
    logic [15:0]       w_unused_addr;

    // Only the low ADDR_W address bits reach the RAM.
    assign w_unused_addr = bus.Core_Addr;
    assign w_core_acc    = bus.Core_Rd | bus.Core_Wr;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            H_IDLE: begin
                if (bus.H_Valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = H_PEND;
                end
            end
            H_PEND: begin
                if (!w_core_acc) begin
                    w_issue     = 1'b1;
                    w_state_nxt = H_IDLE;
                end
            end
            default: w_state_nxt = H_IDLE;
        endcase
        // A pending request is dropped in reset and never reaches the RAM.
        if (Reset) begin
            w_accept    = 1'b0;
            w_issue     = 1'b0;
            w_state_nxt = H_IDLE;
        end
    end

    // RAM pins: core first, otherwise the held host request.
    assign bus.M_En    = w_core_acc | w_issue;
    assign bus.M_We    = w_core_acc ? bus.Core_Wr : (w_issue & r_req_wr);
    assign bus.M_Addr  = w_core_acc ? bus.Core_Addr[ADDR_W-1:0] : r_req_addr;
    assign bus.M_WData = w_core_acc ? bus.Core_WData : r_req_wdata;

    assign bus.Core_RData = bus.M_RData;
    assign bus.Core_Ready = r_core_ready;
    assign bus.H_Ready    = (r_state == H_IDLE) & ~Reset;
    assign bus.H_RValid   = r_rd_vld_p2;
    assign bus.H_RData    = r_rdata_p2;
    assign bus.Starve     = (r_cnt == CNT_MAX);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= H_IDLE;
            r_cnt        <= '0;
            r_rd_vld_p1  <= 1'b0;
            r_rd_vld_p2  <= 1'b0;
            r_rdata_p2   <= '0;
            r_core_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_core_ready <= 1'b1;
            // p1: RAM is presenting the data of a host read issued last cycle
            r_rd_vld_p1  <= w_issue & ~r_req_wr;
            // p2: data captured, H_RValid high for this one cycle
            r_rd_vld_p2  <= r_rd_vld_p1;
            if (r_rd_vld_p1) begin
                r_rdata_p2 <= bus.M_RData;
            end
            if (w_issue) begin
                r_cnt <= '0;
            end else if ((r_state == H_PEND) && w_core_acc && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Holding register carries data only, so it is not reset.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_req_wr    <= bus.H_Wr;
            r_req_addr  <= bus.H_Addr;
            r_req_wdata <= bus.H_WData;
        end
    end

endmodule

// File: tb/tb_mf8_ram_arb.sv
// tb_mf8_ram_arb
//   Self-checking bench for mf8_ram_arb with a behavioural RAM beside it.
//   Directed scenarios cover reset, the core path, host traffic, contention,
//   starvation, reset during a read and simultaneous core strobes; a random
//   phase compares every cycle against a transaction-level reference model.
module tb_mf8_ram_arb;
    import mf8_ram_arb_pkg::*;

    localparam int SMAX = 15;

    typedef struct {
        int         c;
        logic [7:0] d;
    } ret_t;

    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc_n    = 0;

    logic [7:0] ram     [0:255] = '{default: 8'h00};
    logic [7:0] ref_mem [0:255] = '{default: 8'h00};

    mf8_ram_arb_if #(.ADDR_W(8)) bus ();

    mf8_ram_arb #(.ADDR_W(8), .STARVE_MAX(SMAX)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Synchronous single-port RAM
    always @(posedge Clk) begin
        if (bus.M_En) begin
            if (bus.M_We) ram[bus.M_Addr] <= bus.M_WData;
            else          bus.M_RData     <= ram[bus.M_Addr];
        end
    end

    task automatic cyc(input logic rst, input logic crd, input logic cwr, input logic [15:0] ca,
                       input logic [7:0] cwd, input logic hv, input logic hwr, input logic [7:0] ha,
                       input logic [7:0] hwd);
        @(posedge Clk);
        #1;
        cyc_n++;
        Reset          = rst;
        bus.Core_Rd    = crd;
        bus.Core_Wr    = cwr;
        bus.Core_Addr  = ca;
        bus.Core_WData = cwd;
        bus.H_Valid    = hv;
        bus.H_Wr       = hwr;
        bus.H_Addr     = ha;
        bus.H_WData    = hwd;
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
        n_checks++; if (bus.H_Ready !== 1'b0) begin n_errs++; $display("FAIL rst_h_ready: got %b want 0", bus.H_Ready); end
        n_checks++; if (bus.H_RValid !== 1'b0) begin n_errs++; $display("FAIL rst_h_rvalid: got %b want 0", bus.H_RValid); end
        n_checks++; if (bus.H_RData !== 8'h00) begin n_errs++; $display("FAIL rst_h_rdata: got %h want 00", bus.H_RData); end
        n_checks++; if (bus.Starve !== 1'b0) begin n_errs++; $display("FAIL rst_starve: got %b want 0", bus.Starve); end
        n_checks++; if (bus.Core_Ready !== 1'b0) begin n_errs++; $display("FAIL rst_core_ready: got %b want 0", bus.Core_Ready); end
        cyc(1'b1, 1'b1, 1'b0, 16'h00F0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        n_checks++; if (bus.M_En !== 1'b1 || bus.M_We !== 1'b0) begin n_errs++; $display("FAIL rst_core_rd_pins: got en=%b we=%b want 1 0", bus.M_En, bus.M_We); end
        cyc(1'b1, 1'b0, 1'b1, 16'h00F0, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00);
        n_checks++; if (bus.M_En !== 1'b1 || bus.M_We !== 1'b1) begin n_errs++; $display("FAIL rst_core_wr_pins: got en=%b we=%b want 1 1", bus.M_En, bus.M_We); end
        idle();
        n_checks++; if (bus.H_Ready !== 1'b1) begin n_errs++; $display("FAIL rel_h_ready: got %b want 1", bus.H_Ready); end
        n_checks++; if (bus.M_En !== 1'b0) begin n_errs++; $display("FAIL rel_idle_en: got %b want 0", bus.M_En); end
        idle();
        n_checks++; if (bus.Core_Ready !== 1'b1) begin n_errs++; $display("FAIL rel_core_ready: got %b want 1", bus.Core_Ready); end
        ref_mem[8'hF0] = 8'h11;
    endtask

    task automatic test_core_only();
        cyc(1'b0, 1'b0, 1'b1, 16'hAB12, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
        n_checks++; if (bus.M_En !== 1'b1 || bus.M_We !== 1'b1) begin n_errs++; $display("FAIL core_wr_pins: got en=%b we=%b want 1 1", bus.M_En, bus.M_We); end
        n_checks++; if (bus.M_Addr !== 8'h12 || bus.M_WData !== 8'hA5) begin n_errs++; $display("FAIL core_wr_addr_data: got %h/%h want 12/a5", bus.M_Addr, bus.M_WData); end
        cyc(1'b0, 1'b1, 1'b0, 16'h0012, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        n_checks++; if (bus.M_En !== 1'b1 || bus.M_We !== 1'b0) begin n_errs++; $display("FAIL core_rd_pins: got en=%b we=%b want 1 0", bus.M_En, bus.M_We); end
        idle();
        n_checks++; if (bus.Core_RData !== 8'hA5) begin n_errs++; $display("FAIL core_rdata: got %h want a5", bus.Core_RData); end
        n_checks++; if (bus.H_RValid !== 1'b0) begin n_errs++; $display("FAIL core_no_hrvalid: got %b want 0", bus.H_RValid); end
        n_checks++; if (bus.M_En !== 1'b0) begin n_errs++; $display("FAIL core_idle_en: got %b want 0", bus.M_En); end
        ref_mem[8'h12] = 8'hA5;
    endtask

    task automatic test_host_idle();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 8'h40, 8'h3C);
        n_checks++; if (bus.H_Ready !== 1'b1) begin n_errs++; $display("FAIL host_wr_accept: got %b want 1", bus.H_Ready); end
        idle();
        n_checks++; if (bus.H_Ready !== 1'b0) begin n_errs++; $display("FAIL host_pend_ready: got %b want 0", bus.H_Ready); end
        n_checks++; if (bus.M_En !== 1'b1 || bus.M_We !== 1'b1 || bus.M_Addr !== 8'h40 || bus.M_WData !== 8'h3C)
            begin n_errs++; $display("FAIL host_wr_issue: got en=%b we=%b a=%h d=%h want 1 1 40 3c", bus.M_En, bus.M_We, bus.M_Addr, bus.M_WData); end
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
        n_checks++; if (bus.H_Ready !== 1'b1) begin n_errs++; $display("FAIL host_rd_accept: got %b want 1", bus.H_Ready); end
        idle();
        n_checks++; if (bus.M_En !== 1'b1 || bus.M_We !== 1'b0 || bus.M_Addr !== 8'h40)
            begin n_errs++; $display("FAIL host_rd_issue: got en=%b we=%b a=%h want 1 0 40", bus.M_En, bus.M_We, bus.M_Addr); end
        idle();
        n_checks++; if (bus.H_RValid !== 1'b0) begin n_errs++; $display("FAIL host_rd_early: got %b want 0", bus.H_RValid); end
        idle();
        n_checks++; if (bus.H_RValid !== 1'b1 || bus.H_RData !== 8'h3C) begin n_errs++; $display("FAIL host_rd_return: got v=%b d=%h want 1 3c", bus.H_RValid, bus.H_RData); end
        idle();
        n_checks++; if (bus.H_RValid !== 1'b0 || bus.H_RData !== 8'h3C) begin n_errs++; $display("FAIL host_rd_hold: got v=%b d=%h want 0 3c", bus.H_RValid, bus.H_RData); end
        ref_mem[8'h40] = 8'h3C;
    endtask

    task automatic test_contention();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0012, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
            n_checks++; if (bus.M_We !== 1'b0 || bus.M_Addr !== 8'h12 || bus.H_Ready !== 1'b0)
                begin n_errs++; $display("FAIL cont_blocked_%0d: got we=%b a=%h rdy=%b want 0 12 0", k, bus.M_We, bus.M_Addr, bus.H_Ready); end
            if (k > 1) begin
                n_checks++; if (bus.Core_RData !== 8'hA5) begin n_errs++; $display("FAIL cont_core_rdata_%0d: got %h want a5", k, bus.Core_RData); end
            end
        end
        idle();
        n_checks++; if (bus.Core_RData !== 8'hA5) begin n_errs++; $display("FAIL cont_core_rdata_last: got %h want a5", bus.Core_RData); end
        n_checks++; if (bus.M_En !== 1'b1 || bus.M_We !== 1'b0 || bus.M_Addr !== 8'h40)
            begin n_errs++; $display("FAIL cont_issue: got en=%b we=%b a=%h want 1 0 40", bus.M_En, bus.M_We, bus.M_Addr); end
        n_checks++; if (bus.Starve !== 1'b0) begin n_errs++; $display("FAIL cont_starve: got %b want 0", bus.Starve); end
        idle();
        idle();
        n_checks++; if (bus.H_RValid !== 1'b1 || bus.H_RData !== 8'h3C) begin n_errs++; $display("FAIL cont_return: got v=%b d=%h want 1 3c", bus.H_RValid, bus.H_RData); end
    endtask

    task automatic test_starvation();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h12, 8'h00);
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0040, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
            n_checks++; if (bus.Starve !== (k > SMAX)) begin n_errs++; $display("FAIL starve_blk_%0d: got %b want %b", k, bus.Starve, (k > SMAX)); end
        end
        idle();
        n_checks++; if (bus.Starve !== 1'b1 || bus.M_En !== 1'b1 || bus.M_Addr !== 8'h12)
            begin n_errs++; $display("FAIL starve_issue: got s=%b en=%b a=%h want 1 1 12", bus.Starve, bus.M_En, bus.M_Addr); end
        idle();
        n_checks++; if (bus.Starve !== 1'b0) begin n_errs++; $display("FAIL starve_clear: got %b want 0", bus.Starve); end
        idle();
        n_checks++; if (bus.H_RValid !== 1'b1 || bus.H_RData !== 8'hA5) begin n_errs++; $display("FAIL starve_return: got v=%b d=%h want 1 a5", bus.H_RValid, bus.H_RData); end
    endtask

    task automatic test_reset_mid_read();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
        idle();
        n_checks++; if (bus.M_En !== 1'b1 || bus.M_We !== 1'b0 || bus.M_Addr !== 8'h40)
            begin n_errs++; $display("FAIL rmid_issue: got en=%b we=%b a=%h want 1 0 40", bus.M_En, bus.M_We, bus.M_Addr); end
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        n_checks++; if (bus.H_Ready !== 1'b0) begin n_errs++; $display("FAIL rmid_ready_in_rst: got %b want 0", bus.H_Ready); end
        idle();
        n_checks++; if (bus.H_RValid !== 1'b0 || bus.H_RData !== 8'h00) begin n_errs++; $display("FAIL rmid_cancel: got v=%b d=%h want 0 00", bus.H_RValid, bus.H_RData); end
        n_checks++; if (bus.H_Ready !== 1'b1) begin n_errs++; $display("FAIL rmid_ready_after: got %b want 1", bus.H_Ready); end
        idle();
        n_checks++; if (bus.H_RValid !== 1'b0) begin n_errs++; $display("FAIL rmid_no_late_valid: got %b want 0", bus.H_RValid); end
    endtask

    task automatic test_both_strobes();
        cyc(1'b0, 1'b1, 1'b1, 16'h0005, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
        n_checks++; if (bus.M_En !== 1'b1 || bus.M_We !== 1'b1 || bus.M_Addr !== 8'h05 || bus.M_WData !== 8'h77)
            begin n_errs++; $display("FAIL both_pins: got en=%b we=%b a=%h d=%h want 1 1 05 77", bus.M_En, bus.M_We, bus.M_Addr, bus.M_WData); end
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00);
        n_checks++; if (bus.H_Ready !== 1'b1) begin n_errs++; $display("FAIL both_accept: got %b want 1", bus.H_Ready); end
        idle();
        idle();
        idle();
        n_checks++; if (bus.H_RValid !== 1'b1 || bus.H_RData !== 8'h77) begin n_errs++; $display("FAIL both_return: got v=%b d=%h want 1 77", bus.H_RValid, bus.H_RData); end
        ref_mem[8'h05] = 8'h77;
    endtask

    // Reference: the core owns the RAM whenever it strobes; one host request
    // at a time waits for a free cycle; reads return two cycles after issue.
    task automatic test_random();
        bit         m_pend = 1'b0;
        bit         m_wr   = 1'b0;
        logic [7:0] m_addr = 8'h00;
        logic [7:0] m_wd   = 8'h00;
        int         m_cnt  = 0;
        bit         prev_crd = 1'b0;
        logic [7:0] prev_cd  = 8'h00;
        ret_t       rq[$];
        logic       crd, cwr, hv, hwr;
        logic [15:0] ca;
        logic [7:0] cwd, ha, hwd;
        bit         core, issue, accept, exp_rv;
        for (int i = 0; i < 600; i++) begin
            if (i < 590) begin
                crd = ($urandom_range(0, 99) < 40);
                cwr = ($urandom_range(0, 99) < 20);
                ca  = {8'($urandom), 4'h8, 4'($urandom)};
                cwd = 8'($urandom);
                hv  = ($urandom_range(0, 99) < 60);
                hwr = ($urandom_range(0, 99) < 50);
                ha  = {4'h8, 4'($urandom)};
                hwd = 8'($urandom);
            end else begin
                crd = 1'b0; cwr = 1'b0; ca = 16'h0000; cwd = 8'h00;
                hv  = 1'b0; hwr = 1'b0; ha = 8'h00; hwd = 8'h00;
            end
            cyc(1'b0, crd, cwr, ca, cwd, hv, hwr, ha, hwd);
            core   = crd | cwr;
            issue  = m_pend && !core;
            accept = hv && !m_pend;
            n_checks++; if (bus.H_Ready !== !m_pend) begin n_errs++; $display("FAIL rnd_h_ready c%0d: got %b want %b", cyc_n, bus.H_Ready, !m_pend); end
            n_checks++; if (bus.M_En !== (core | issue)) begin n_errs++; $display("FAIL rnd_m_en c%0d: got %b want %b", cyc_n, bus.M_En, core | issue); end
            n_checks++; if (bus.M_We !== (core ? cwr : (issue & m_wr))) begin n_errs++; $display("FAIL rnd_m_we c%0d: got %b want %b", cyc_n, bus.M_We, core ? cwr : (issue & m_wr)); end
            if (core || issue) begin
                n_checks++; if (bus.M_Addr !== (core ? ca[7:0] : m_addr)) begin n_errs++; $display("FAIL rnd_m_addr c%0d: got %h want %h", cyc_n, bus.M_Addr, core ? ca[7:0] : m_addr); end
            end
            if (core ? cwr : (issue && m_wr)) begin
                n_checks++; if (bus.M_WData !== (core ? cwd : m_wd)) begin n_errs++; $display("FAIL rnd_m_wdata c%0d: got %h want %h", cyc_n, bus.M_WData, core ? cwd : m_wd); end
            end
            n_checks++; if (bus.Starve !== (m_cnt == SMAX)) begin n_errs++; $display("FAIL rnd_starve c%0d: got %b want %b", cyc_n, bus.Starve, m_cnt == SMAX); end
            exp_rv = (rq.size() > 0) && (rq[0].c == cyc_n);
            n_checks++; if (bus.H_RValid !== exp_rv) begin n_errs++; $display("FAIL rnd_h_rvalid c%0d: got %b want %b", cyc_n, bus.H_RValid, exp_rv); end
            if (exp_rv) begin
                n_checks++; if (bus.H_RData !== rq[0].d) begin n_errs++; $display("FAIL rnd_h_rdata c%0d: got %h want %h", cyc_n, bus.H_RData, rq[0].d); end
                void'(rq.pop_front());
            end
            if (prev_crd) begin
                n_checks++; if (bus.Core_RData !== prev_cd) begin n_errs++; $display("FAIL rnd_core_rdata c%0d: got %h want %h", cyc_n, bus.Core_RData, prev_cd); end
            end
            n_checks++; if (bus.Core_Ready !== 1'b1) begin n_errs++; $display("FAIL rnd_core_ready c%0d: got %b want 1", cyc_n, bus.Core_Ready); end
            // advance the reference to the end of this cycle
            prev_crd = crd && !cwr;
            if (prev_crd) prev_cd = ref_mem[ca[7:0]];
            if (cwr) ref_mem[ca[7:0]] = cwd;
            if (issue) begin
                if (m_wr) ref_mem[m_addr] = m_wd;
                else      rq.push_back('{cyc_n + 2, ref_mem[m_addr]});
                m_pend = 1'b0;
                m_cnt  = 0;
            end else if (m_pend && core && m_cnt < SMAX) begin
                m_cnt++;
            end
            if (accept) begin
                m_pend = 1'b1;
                m_wr   = hwr;
                m_addr = ha;
                m_wd   = hwd;
            end
        end
        n_checks++; if (rq.size() != 0) begin n_errs++; $display("FAIL rnd_missing_returns: got %0d outstanding want 0", rq.size()); end
    endtask

    initial begin
        Reset          = 1'b1;
        bus.Core_Rd    = 1'b0;
        bus.Core_Wr    = 1'b0;
        bus.Core_Addr  = 16'h0000;
        bus.Core_WData = 8'h00;
        bus.H_Valid    = 1'b0;
        bus.H_Wr       = 1'b0;
        bus.H_Addr     = 8'h00;
        bus.H_WData    = 8'h00;
        test_reset();
        test_core_only();
        test_host_idle();
        test_contention();
        test_starvation();
        test_reset_mid_read();
        test_both_strobes();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
